// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token and guard-band codes plus the
// period-state enum used by both the encoder and the decoder.
package tmds_pkg;

  localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTL_TOKEN_11 = 10'b1010101011;

  // Guard-band code differs by channel: channels 0 and 2 share one code.
  localparam logic [9:0] GB_CODE_02 = 10'b1011001100;
  localparam logic [9:0] GB_CODE_1  = 10'b0100110011;

  typedef enum logic [1:0] {
    CTRL  = 2'd0,
    GUARD = 2'd1,
    VIDEO = 2'd2
  } period_e;

endpackage

// File: rtl/tmds_sym_dec.sv
// Combinational TMDS video-symbol decode (10b to 8b) and 10-bit popcount
// used for running-disparity tracking.
module tmds_sym_dec
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic [3:0] ones
);

  logic [7:0] d;

  always_comb begin
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = d[0];
    // sym[8] selects the XOR (1) or XNOR (0) transition chain used by the encoder.
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, sym[i]};
    end
  end

endmodule

// File: rtl/tmds_dec.sv
// Per-channel TMDS symbol decoder: classifies each aligned symbol, recovers
// pixel/control/guard information, tracks running disparity and channel lock.
module tmds_dec
  import tmds_pkg::*;
#(
  parameter int TMDS_CHANNEL = 0,
  parameter int LOCK_CNT     = 8,
  parameter int ERR_MAX      = 4,
  parameter int DISP_MAX     = 12
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [9:0] tmds_data_i,
  output logic [7:0] px_data_o,
  output logic       px_data_val_o,
  output logic       gb_o,
  output logic       ctl_0_o,
  output logic       ctl_1_o,
  output logic       sym_err_o,
  output logic       locked_o
);

  // Stream interface: no valid/ready handshake and no backpressure; every
  // clock consumes exactly one symbol and produces one output set.

  localparam int OK_W  = $clog2(LOCK_CNT + 1);
  localparam int ERR_W = $clog2(ERR_MAX + 1);
  localparam logic [OK_W-1:0]  OK_TOP  = OK_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_TOP = ERR_W'(ERR_MAX);
  localparam logic [9:0] GB_CODE = (TMDS_CHANNEL == 1) ? GB_CODE_1 : GB_CODE_02;
  localparam logic signed [6:0] RD_MAX   = 7'sd31;
  localparam logic signed [6:0] RD_MIN   = -7'sd31;
  localparam logic signed [6:0] DISP_LIM = 7'(DISP_MAX);

  // ---------------------------------------------------------------- stage 1
  logic       in_ctrl;
  logic [1:0] in_ctl;
  logic       in_gb_code;

  period_e    period_q;
  logic [9:0] s1_sym;
  logic       s1_vld;
  logic       s1_ctrl;
  logic       s1_gb;
  logic [1:0] s1_ctl;
  logic       s1_lock;
  logic       s1_video;

  always_comb begin
    in_ctrl = 1'b1;
    in_ctl  = 2'b00;
    case (tmds_data_i)
      CTL_TOKEN_00: in_ctl = 2'b00;
      CTL_TOKEN_01: in_ctl = 2'b01;
      CTL_TOKEN_10: in_ctl = 2'b10;
      CTL_TOKEN_11: in_ctl = 2'b11;
      default:      in_ctrl = 1'b0;
    endcase
    in_gb_code = (tmds_data_i == GB_CODE);
  end

  // Period FSM together with the registered classification flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period_q <= CTRL;
      s1_sym   <= '0;
      s1_vld   <= 1'b0;
      s1_ctrl  <= 1'b0;
      s1_gb    <= 1'b0;
      s1_ctl   <= 2'b00;
      s1_lock  <= 1'b0;
    end else begin
      s1_vld  <= 1'b1;
      s1_sym  <= tmds_data_i;
      s1_ctl  <= in_ctl;
      s1_lock <= locked_o;
      if (in_ctrl) begin
        period_q <= CTRL;
        s1_ctrl  <= 1'b1;
        s1_gb    <= 1'b0;
      end else if (in_gb_code && (period_q != VIDEO)) begin
        period_q <= GUARD;
        s1_ctrl  <= 1'b0;
        s1_gb    <= 1'b1;
      end else begin
        // Inside VIDEO a guard-band code is just pixel data.
        period_q <= VIDEO;
        s1_ctrl  <= 1'b0;
        s1_gb    <= 1'b0;
      end
    end
  end

  assign s1_video = s1_vld && !s1_ctrl && !s1_gb;

  // ---------------------------------------------------------------- stage 2
  logic [7:0]        dec_data;
  logic [3:0]        sym_ones;
  logic signed [5:0] rd_q;
  logic signed [6:0] rd_sum;
  logic signed [6:0] rd_sat;
  logic              disp_err;
  logic [OK_W-1:0]   ok_cnt;
  logic [ERR_W-1:0]  err_cnt;

  tmds_sym_dec u_sym_dec (
    .sym  (s1_sym),
    .data (dec_data),
    .ones (sym_ones)
  );

  // Each symbol shifts disparity by (ones - zeros) = 2*ones - 10.
  assign rd_sum = {rd_q[5], rd_q} + {2'b00, sym_ones, 1'b0} - 7'sd10;

  always_comb begin
    rd_sat = rd_sum;
    if (rd_sum > RD_MAX) begin
      rd_sat = RD_MAX;
    end else if (rd_sum < RD_MIN) begin
      rd_sat = RD_MIN;
    end
    disp_err = (rd_sat > DISP_LIM) || (rd_sat < -DISP_LIM);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      px_data_o     <= '0;
      px_data_val_o <= 1'b0;
      gb_o          <= 1'b0;
      ctl_0_o       <= 1'b0;
      ctl_1_o       <= 1'b0;
      sym_err_o     <= 1'b0;
      rd_q          <= '0;
      ok_cnt        <= '0;
      err_cnt       <= '0;
    end else begin
      gb_o          <= s1_gb;
      px_data_val_o <= s1_video && s1_lock;
      sym_err_o     <= s1_video && disp_err;

      if (s1_ctrl) begin
        ctl_0_o <= s1_ctl[0];
        ctl_1_o <= s1_ctl[1];
      end

      if (s1_video) begin
        px_data_o <= dec_data;
      end

      if (s1_ctrl || s1_gb) begin
        rd_q <= '0;
      end else if (s1_video) begin
        rd_q <= disp_err ? 6'sd0 : rd_sat[5:0];
      end

      if (s1_ctrl) begin
        ok_cnt <= (ok_cnt == OK_TOP) ? ok_cnt : ok_cnt + OK_W'(1);
      end else begin
        ok_cnt <= '0;
      end

      if (s1_video && disp_err) begin
        err_cnt <= (err_cnt == ERR_TOP) ? err_cnt : err_cnt + ERR_W'(1);
      end else begin
        err_cnt <= '0;
      end
    end
  end

  // Lock follows the counters one cycle later; loss of lock has priority.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      locked_o <= 1'b0;
    end else if (err_cnt == ERR_TOP) begin
      locked_o <= 1'b0;
    end else if (ok_cnt == OK_TOP) begin
      locked_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tmds_dec.sv
// Directed testbench for tmds_dec: a default-parameter instance plus a
// tight-disparity instance (DISP_MAX=4) fed the same symbol stream.
module tb_tmds_dec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] tmds_data = '0;

  logic [7:0] px_data,     px_data_e;
  logic       px_val,      px_val_e;
  logic       gb,          gb_e;
  logic       ctl0,        ctl0_e;
  logic       ctl1,        ctl1_e;
  logic       sym_err,     sym_err_e;
  logic       locked,      locked_e;
  logic [13:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] CTL01 = 10'b0010101011;
  localparam logic [9:0] CTL11 = 10'b1010101011;
  localparam logic [9:0] GB0   = 10'b1011001100;
  localparam logic [9:0] V0    = 10'b0100000000; // decodes to 0x00, -8
  localparam logic [9:0] V1    = 10'b0111110000; // decodes to 0x10, +0
  localparam logic [9:0] V2    = 10'b1000001111; // decodes to 0xEE, +0
  localparam logic [9:0] SD    = 10'b1111111100; // decodes to 0x05, +6

  // ---------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  tmds_dec dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .tmds_data_i   (tmds_data),
    .px_data_o     (px_data),
    .px_data_val_o (px_val),
    .gb_o          (gb),
    .ctl_0_o       (ctl0),
    .ctl_1_o       (ctl1),
    .sym_err_o     (sym_err),
    .locked_o      (locked)
  );

  tmds_dec #(.DISP_MAX(4)) dut_e (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .tmds_data_i   (tmds_data),
    .px_data_o     (px_data_e),
    .px_data_val_o (px_val_e),
    .gb_o          (gb_e),
    .ctl_0_o       (ctl0_e),
    .ctl_1_o       (ctl1_e),
    .sym_err_o     (sym_err_e),
    .locked_o      (locked_e)
  );

  assign dut_vec = {px_data, px_val, gb, ctl1, ctl0, sym_err, locked};

  // ---------------------------------------------------------- driver tasks
  // After push() returns, outputs show the previous symbol and locked_o
  // reflects the one before that.
  task automatic push(input logic [9:0] sym);
    tmds_data = sym;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_vec", 32'(dut_vec), 0);
    check("reset_locked_e", 32'(locked_e), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 10; i++) begin
      push(CTL00);
      if (i == 9) check("lock_early", 32'(locked), 0);
      if (i == 10) begin
        check("lock_set", 32'(locked), 1);
        check("lock_set_e", 32'(locked_e), 1);
        check("ctl_00", 32'({ctl1, ctl0}), 0);
      end
    end

    push(GB0);
    check("gb_pre", 32'(gb), 0);
    push(GB0);
    check("gb_1", 32'(gb), 1);
    push(V0);
    check("gb_2", 32'(gb), 1);
    push(GB0);
    check("vid0_px", 32'(px_data), 8'h00);
    check("vid0_val", 32'(px_val), 1);
    check("vid0_gb", 32'(gb), 0);
    push(CTL01);
    check("gbvid_px", 32'(px_data), 8'hAB);
    check("gbvid_gb", 32'(gb), 0);
    check("gbvid_val", 32'(px_val), 1);
    check("gbvid_err", 32'(sym_err), 0);

    push(V1);
    check("ctl01", 32'({ctl1, ctl0}), 2'b01);
    check("ctl01_val", 32'(px_val), 0);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'hEE);
    push(V2);
    check("run_px", 32'(px_data), 32'(exp_q.pop_front()));
    check("run_ctl", 32'({ctl1, ctl0}), 2'b01);
    push(CTL11);
    check("run_px", 32'(px_data), 32'(exp_q.pop_front()));
    check("run_ctl", 32'({ctl1, ctl0}), 2'b01);
    check("run_val", 32'(px_val), 1);
    push(CTL11);
    check("ctl11", 32'({ctl1, ctl0}), 2'b11);
    check("ctl11_px_hold", 32'(px_data), 8'hEE);
    check("ctl11_val", 32'(px_val), 0);
    check("lock_hold", 32'(locked), 1);

    // +6 disparity per symbol from rd=0: errors at 18 for DISP_MAX=12,
    // and on every symbol for DISP_MAX=4.
    push(SD);
    push(SD);
    check("disp1_err", 32'(sym_err), 0);
    check("disp1_px", 32'(px_data), 8'h05);
    check("disp1_val", 32'(px_val), 1);
    check("disp1_err_e", 32'(sym_err_e), 1);
    push(SD);
    check("disp2_err", 32'(sym_err), 0);
    check("disp2_err_e", 32'(sym_err_e), 1);
    push(SD);
    check("disp3_err", 32'(sym_err), 1);
    check("disp3_err_e", 32'(sym_err_e), 1);
    push(SD);
    check("disp4_err", 32'(sym_err), 0);
    check("disp4_err_e", 32'(sym_err_e), 1);
    check("disp4_locked_e", 32'(locked_e), 1);
    push(SD);
    check("unlock_e", 32'(locked_e), 0);
    check("keep_lock", 32'(locked), 1);
    push(SD);
    check("disp6_err", 32'(sym_err), 1);
    push(SD);
    check("unlocked_val_e", 32'(px_val_e), 0);
    check("locked_val", 32'(px_val), 1);

    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_vec", 32'(dut_vec), 0);
    check("rst_mid_px_e", 32'(px_data_e), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    push(V1);
    push(V1);
    check("post_rst_px", 32'(px_data), 8'h10);
    check("post_rst_val", 32'(px_val), 0);
    check("post_rst_locked", 32'(locked), 0);
    for (int i = 1; i <= 10; i++) begin
      push(CTL00);
      if (i == 9) check("relock_early", 32'(locked), 0);
      if (i == 10) check("relock", 32'(locked), 1);
    end
    push(V2);
    push(V1);
    check("relock_px", 32'(px_data), 8'hEE);
    check("relock_val", 32'(px_val), 1);
    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
